// File: rtl/bcd_pkg.sv
// Shared constants and FSM state encoding for the serial binary-to-BCD converter.
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SHIFT = 2'd1;
   localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [BCD_DIGIT_W-1:0] o_digit
);

   always_comb begin
      o_digit = i_digit;
      if (i_digit >= 4'd5) begin
         o_digit = i_digit + 4'd3;
      end
   end

endmodule

// File: rtl/bcd_serial_conv.sv
// Serial binary-to-BCD converter (double dabble), one operand bit per clock, with
// a sticky overflow flag when the value needs more than DIGITS digits.
module bcd_serial_conv
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 11,
   parameter int DIGITS = 4
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [WIDTH-1:0]              bin,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                          overflow
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = BCD_DIGIT_W * DIGITS;

   state_t          r_state;
   logic [CW-1:0]   r_count;
   logic [WIDTH-1:0] r_operand;
   logic [SW-1:0]   r_scratch;
   logic            r_sticky;
   logic [SW-1:0]   r_bcd;
   logic            r_ovf;

   logic [SW-1:0]   w_adj;
   logic [SW-1:0]   w_shifted;
   logic            w_topLost;
   logic            w_lastShift;

   for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_digit (r_scratch[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .o_digit (w_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // The adjusted top bit falls off the end on the shift, so it marks a lost decade.
   assign w_shifted   = {w_adj[SW-2:0], r_operand[WIDTH-1]};
   assign w_topLost   = w_adj[SW-1];
   assign w_lastShift = (r_count == CW'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_operand <= '0;
         r_scratch <= '0;
         r_sticky  <= 1'b0;
         r_bcd     <= '0;
         r_ovf     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_operand <= bin;
                  r_scratch <= '0;
                  r_sticky  <= 1'b0;
                  r_count   <= CW'(WIDTH);
                  r_state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_scratch <= w_shifted;
               r_operand <= {r_operand[WIDTH-2:0], 1'b0};
               r_count   <= r_count - CW'(1);
               r_sticky  <= r_sticky | w_topLost;
               // Publish the final digits together with done so they are valid during the pulse.
               if (w_lastShift) begin
                  r_bcd   <= w_shifted;
                  r_ovf   <= r_sticky | w_topLost;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = (r_state == ST_SHIFT);
   assign done     = (r_state == ST_DONE);
   assign bcd      = r_bcd;
   assign overflow = r_ovf;

endmodule

// File: doc/bcd_serial_conv.md
BCD_SERIAL_CONV -- requirements
Module: bcd_serial_conv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 11, giving the binary input width (legal 4..32).
REQ-002 The block SHALL have parameter DIGITS, default 4, giving the number of BCD output digits (legal 1..10).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to convert the value on bin; sampled only in IDLE.
REQ-006 The block SHALL have port bin, input, WIDTH bits: unsigned binary operand; captured on the accepted start edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress (SHIFT state).
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when a new result is valid.
REQ-009 The block SHALL have port bcd, output, 4*DIGITS bits: digit k in bits [4k+3:4k], digit 0 = ones.
REQ-010 The block SHALL have port overflow, output, 1 bit: high when the result does not fit in DIGITS digits; valid with bcd.

Function
REQ-011 The block SHALL implement shift-add-3 (double dabble) conversion, one input bit per clock.
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; reset enters IDLE.
REQ-013 In IDLE with start=1, the block SHALL latch bin, clear the digit scratch and the overflow sticky bit, load the bit counter with WIDTH, and enter SHIFT.
REQ-014 In IDLE with start=0, the block SHALL hold all registers unchanged.
REQ-015 Each SHIFT cycle SHALL first add 3 to every scratch digit >= 5, then shift {scratch, operand} left by one with the operand MSB entering digit 0 LSB, and decrement the counter.
REQ-016 If the adjusted top digit has bit 3 set before a shift, the overflow sticky bit SHALL be set.
REQ-017 After the cycle in which the counter reaches 0, the FSM SHALL enter DONE.
REQ-018 In DONE, the block SHALL copy scratch to bcd and the sticky bit to overflow, pulse done for exactly one cycle, and return to IDLE.
REQ-019 done SHALL be high in the cycle exactly WIDTH+1 clocks after the accepted start edge (12 clocks for WIDTH=11).
REQ-020 start SHALL be ignored in the SHIFT and DONE states; minimum start-to-start spacing is WIDTH+2 clocks.
REQ-021 bcd and overflow SHALL hold their last result until the next done and SHALL not change during SHIFT.
REQ-022 When overflow=1, bcd SHALL equal the true value modulo 10^DIGITS.
REQ-023 busy SHALL be high only in SHIFT, and done SHALL be high only in DONE; the two are never high together.
REQ-024 No output SHALL be combinationally dependent on start or bin.

Reset
REQ-025 Assertion of reset at any time, including mid-conversion, SHALL immediately force state=IDLE, busy=0, done=0, bcd=0, overflow=0, counter=0 and scratch=0.
REQ-026 The first start after reset deassertion SHALL be accepted normally, and no partial result from an aborted conversion SHALL appear.

Structure
REQ-027 A shared package bcd_pkg SHALL hold the constant BCD_DIGIT_W=4 and the FSM state typedef.
REQ-028 A sub-module bcd_digit_adj SHALL be used, one instance per digit, performing the combinational "if >= 5 add 3" on a 4-bit digit.
REQ-029 The counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-030 Scenario: defaults, bin=0, start pulse -> done 12 clocks later, bcd=16'h0000, overflow=0.
REQ-031 Scenario: defaults, bin=2047 -> bcd=16'h2047, overflow=0; also bin=1999 -> 16'h1999.
REQ-032 Scenario: defaults, start=1 held continuously with bin changing -> one conversion per 13 clocks, each result matching the bin value at its accepting edge.
REQ-033 Scenario: reset asserted 5 clocks into a conversion of bin=1234, then start with bin=7 -> bcd=16'h0007 with no glitch to a 1234-derived value.
REQ-034 Scenario: WIDTH=16, DIGITS=5, bin=65535 -> bcd=20'h65535, done 17 clocks after start, overflow=0.
REQ-035 Scenario: WIDTH=11, DIGITS=3, bin=1000 -> bcd=12'h000, overflow=1; bin=999 -> 12'h999, overflow=0.
